multicycle_ctrl: RTL and testbench

- Control-unit FSM for the multicycle RV32I core variant (LW, SW, R-type ALU, I-type ALU, BEQ, JAL).
- Sequences a shared datapath: one ALU, one unified instruction/data memory, non-architectural IR/OldPC/Data/ALUOut registers.
- Sits between the instruction register and datapath select/enable lines.
- Handshakes with memory through a ready signal so that memory latency may vary.

---
 rtl/multicycle_ctrl_if.sv | 40 ++++
 rtl/multicycle_ctrl.sv | 180 ++++++++++++++++++
 tb/tb_multicycle_ctrl.sv | 223 ++++++++++++++++++++++
 3 files changed

// File: rtl/multicycle_ctrl_if.sv
// Instruction-field / datapath-control bundle between multicycle_ctrl and its datapath.
// MULTICYCLE_CTRL_ILLEGAL_TRAP_EN adds the o_illegalInstr flag.
interface multicycle_ctrl_if;
  logic [6:0] i_op;
  logic [2:0] i_funct3;
  logic       i_funct7b5;
  logic       i_zero;
  logic       i_memReady;
  logic       o_pcWrite;
  logic       o_adrSrc;
  logic       o_memWrite;
  logic       o_irWrite;
  logic [1:0] o_resultSrc;
  logic [1:0] o_aluSrcA;
  logic [1:0] o_aluSrcB;
  logic [1:0] o_immSrc;
  logic       o_regWrite;
  logic [3:0] o_aluControl;
`ifdef MULTICYCLE_CTRL_ILLEGAL_TRAP_EN
  logic       o_illegalInstr;
`endif

  modport master (
`ifdef MULTICYCLE_CTRL_ILLEGAL_TRAP_EN
    output o_illegalInstr,
`endif
    input  i_op, i_funct3, i_funct7b5, i_zero, i_memReady,
    output o_pcWrite, o_adrSrc, o_memWrite, o_irWrite, o_resultSrc,
    output o_aluSrcA, o_aluSrcB, o_immSrc, o_regWrite, o_aluControl
  );

  modport slave (
`ifdef MULTICYCLE_CTRL_ILLEGAL_TRAP_EN
    input  o_illegalInstr,
`endif
    output i_op, i_funct3, i_funct7b5, i_zero, i_memReady,
    input  o_pcWrite, o_adrSrc, o_memWrite, o_irWrite, o_resultSrc,
    input  o_aluSrcA, o_aluSrcB, o_immSrc, o_regWrite, o_aluControl
  );
endinterface

// File: rtl/multicycle_ctrl.sv
// Moore control FSM for the multicycle RV32I core (LW, SW, R/I ALU, BEQ, JAL).
// Optional MULTICYCLE_CTRL_ILLEGAL_TRAP_EN: unsupported opcodes lock in TRAP until reset.
module multicycle_ctrl (
  input  logic i_clk,
  input  logic i_rst_n,
  multicycle_ctrl_if.master bus
);
  localparam logic [6:0] OP_LW   = 7'b0000011;
  localparam logic [6:0] OP_SW   = 7'b0100011;
  localparam logic [6:0] OP_R    = 7'b0110011;
  localparam logic [6:0] OP_I    = 7'b0010011;
  localparam logic [6:0] OP_B    = 7'b1100011;
  localparam logic [6:0] OP_JAL  = 7'b1101111;

  localparam logic [3:0] ALU_ADD = 4'b0000;
  localparam logic [3:0] ALU_SUB = 4'b1000;

  typedef enum logic [3:0] {
    FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE,
    EXECR, EXECI, ALUWB, BEQ, JAL, TRAP
  } state_e;

  typedef struct packed {
    logic       adr_src;
    logic       mem_write;
    logic       reg_write;
    logic       pc_jump;
    logic [1:0] result_src;
    logic [1:0] alu_src_a;
    logic [1:0] alu_src_b;
    logic [3:0] alu_ctl;
    logic       illegal;
  } ctrl_t;

  localparam ctrl_t CTRL_FETCH = '{result_src: 2'b10, alu_src_b: 2'b10, default: '0};

  state_e state_q, state_d;
  ctrl_t  ctrl_q;

  function automatic logic [3:0] alu_decode(logic [1:0] alu_op, logic [2:0] f3,
                                            logic b5, logic op5);
    logic [3:0] r;
    r = ALU_ADD;
    case (alu_op)
      2'b00: r = ALU_ADD;
      2'b01: r = ALU_SUB;
      default: begin
        case (f3)
          // bit 30 only selects SUB for register-register forms, so ADDI ignores it
          3'b000:                 r = (b5 && op5) ? ALU_SUB : ALU_ADD;
          3'b010, 3'b110, 3'b111: r = {1'b0, f3};
          default:                r = ALU_ADD;
        endcase
      end
    endcase
    return r;
  endfunction

  function automatic ctrl_t ctrl_of(state_e s, logic [6:0] op, logic [2:0] f3, logic b5);
    ctrl_t c;
    c = '0;
    case (s)
      FETCH:    c = CTRL_FETCH;
      DECODE: begin
        c.alu_src_a = 2'b01;
        c.alu_src_b = 2'b01;
        c.alu_ctl   = alu_decode(2'b00, f3, b5, op[5]);
      end
      MEMADR: begin
        c.alu_src_a = 2'b10;
        c.alu_src_b = 2'b01;
        c.alu_ctl   = alu_decode(2'b00, f3, b5, op[5]);
      end
      MEMREAD:  c.adr_src = 1'b1;
      MEMWB: begin
        c.result_src = 2'b01;
        c.reg_write  = 1'b1;
      end
      MEMWRITE: begin
        c.adr_src   = 1'b1;
        c.mem_write = 1'b1;
      end
      EXECR: begin
        c.alu_src_a = 2'b10;
        c.alu_ctl   = alu_decode(2'b10, f3, b5, op[5]);
      end
      EXECI: begin
        c.alu_src_a = 2'b10;
        c.alu_src_b = 2'b01;
        c.alu_ctl   = alu_decode(2'b10, f3, b5, op[5]);
      end
      ALUWB:    c.reg_write = 1'b1;
      BEQ: begin
        c.alu_src_a = 2'b10;
        c.alu_ctl   = alu_decode(2'b01, f3, b5, op[5]);
      end
      JAL: begin
        c.alu_src_a = 2'b01;
        c.alu_src_b = 2'b10;
        c.pc_jump   = 1'b1;
        c.alu_ctl   = alu_decode(2'b00, f3, b5, op[5]);
      end
      TRAP:     c.illegal = 1'b1;
      default:  c = CTRL_FETCH;
    endcase
    return c;
  endfunction

  always_comb begin
    state_d = state_q;
    case (state_q)
      FETCH:    if (bus.i_memReady) state_d = DECODE;
      DECODE: begin
        case (bus.i_op)
          OP_LW, OP_SW: state_d = MEMADR;
          OP_R:         state_d = EXECR;
          OP_I:         state_d = EXECI;
          OP_JAL:       state_d = JAL;
          OP_B:         state_d = BEQ;
`ifdef MULTICYCLE_CTRL_ILLEGAL_TRAP_EN
          default:      state_d = TRAP;
`else
          default:      state_d = FETCH;
`endif
        endcase
      end
      MEMADR:   state_d = (bus.i_op == OP_LW) ? MEMREAD : MEMWRITE;
      MEMREAD:  if (bus.i_memReady) state_d = MEMWB;
      MEMWB:    state_d = FETCH;
      MEMWRITE: if (bus.i_memReady) state_d = FETCH;
      EXECR,
      EXECI:    state_d = ALUWB;
      ALUWB:    state_d = FETCH;
      BEQ:      state_d = FETCH;
      JAL:      state_d = ALUWB;
      TRAP:     state_d = TRAP;
      default:  state_d = FETCH;
    endcase
  end

  // Selects and unqualified enables are registered against the next state,
  // so they are valid from the first cycle of each state.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= FETCH;
      ctrl_q  <= CTRL_FETCH;
    end else begin
      state_q <= state_d;
      ctrl_q  <= ctrl_of(state_d, bus.i_op, bus.i_funct3, bus.i_funct7b5);
    end
  end

  logic fetch_done;
  assign fetch_done = (state_q == FETCH) && bus.i_memReady;

  // Qualified enables follow i_memReady / i_zero combinationally; gate with
  // reset so FETCH's handshake cannot leak out while reset is held.
  assign bus.o_irWrite    = i_rst_n && fetch_done;
  assign bus.o_pcWrite    = i_rst_n && (fetch_done || ctrl_q.pc_jump ||
                                        ((state_q == BEQ) && bus.i_zero));
  assign bus.o_memWrite   = ctrl_q.mem_write;
  assign bus.o_regWrite   = ctrl_q.reg_write;
  assign bus.o_adrSrc     = ctrl_q.adr_src;
  assign bus.o_resultSrc  = ctrl_q.result_src;
  assign bus.o_aluSrcA    = ctrl_q.alu_src_a;
  assign bus.o_aluSrcB    = ctrl_q.alu_src_b;
  assign bus.o_aluControl = ctrl_q.alu_ctl;
`ifdef MULTICYCLE_CTRL_ILLEGAL_TRAP_EN
  assign bus.o_illegalInstr = ctrl_q.illegal;
`endif

  always_comb begin
    case (bus.i_op)
      OP_SW:   bus.o_immSrc = 2'b01;
      OP_B:    bus.o_immSrc = 2'b10;
      OP_JAL:  bus.o_immSrc = 2'b11;
      default: bus.o_immSrc = 2'b00;
    endcase
  end
endmodule

// File: tb/tb_multicycle_ctrl.sv
// Scoreboard bench for multicycle_ctrl: per-cycle expected control words are queued
// when an instruction is issued and compared each cycle as the FSM walks it.
module tb_multicycle_ctrl;
  logic i_clk = 1'b0;
  logic i_rst_n = 1'b0;
  always #5 i_clk = ~i_clk;

  multicycle_ctrl_if bus();
  multicycle_ctrl dut (.i_clk(i_clk), .i_rst_n(i_rst_n), .bus(bus));

  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_B   = 7'b1100011;
  localparam logic [6:0] OP_JAL = 7'b1101111;
  localparam logic [6:0] OP_SYS = 7'b1110011;

  typedef struct {
    string      tag;
    logic       rdy;
    logic       z;
    logic [17:0] exp;
  } cyc_t;

  cyc_t sb[$];
  int   n_run = 0;
  int   n_fail = 0;
  logic [1:0] cur_imm = 2'b00;
  string cur_name = "";

  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [1:0] imm_of(logic [6:0] op);
    case (op)
      OP_SW:   return 2'b01;
      OP_B:    return 2'b10;
      OP_JAL:  return 2'b11;
      default: return 2'b00;
    endcase
  endfunction

  function automatic logic [3:0] exp_alu(logic [6:0] op, logic [2:0] f3, logic b30);
    case (f3)
      3'b000:                 return (b30 && op == OP_R) ? 4'b1000 : 4'b0000;
      3'b010, 3'b110, 3'b111: return {1'b0, f3};
      default:                return 4'b0000;
    endcase
  endfunction

  // {illegal, immSrc, pcWrite, adrSrc, memWrite, irWrite, resultSrc, aluSrcA, aluSrcB, regWrite, aluControl}
  function automatic logic [17:0] mk(logic pcw, logic adr, logic mw, logic irw, logic [1:0] rs,
                                     logic [1:0] a, logic [1:0] b, logic rw, logic [3:0] alu);
    return {1'b0, cur_imm, pcw, adr, mw, irw, rs, a, b, rw, alu};
  endfunction

  function automatic logic [17:0] obs();
    logic ill;
`ifdef MULTICYCLE_CTRL_ILLEGAL_TRAP_EN
    ill = bus.o_illegalInstr;
`else
    ill = 1'b0;
`endif
    return {ill, bus.o_immSrc, bus.o_pcWrite, bus.o_adrSrc, bus.o_memWrite, bus.o_irWrite,
            bus.o_resultSrc, bus.o_aluSrcA, bus.o_aluSrcB, bus.o_regWrite, bus.o_aluControl};
  endfunction

  function automatic logic [17:0] e_fetch(logic rdy);
    return mk(rdy, 1'b0, 1'b0, rdy, 2'b10, 2'b00, 2'b10, 1'b0, 4'b0000);
  endfunction

  task automatic push(string st, logic rdy, logic z, logic [17:0] e);
    cyc_t c;
    c.tag = {cur_name, "/", st};
    c.rdy = rdy;
    c.z   = z;
    c.exp = e;
    sb.push_back(c);
  endtask

  function automatic logic rnd();
    return 1'($urandom_range(0, 1));
  endfunction

  // Issue one instruction: drive its fields and queue the expected cycle trace.
  task automatic issue(string name, logic [6:0] op, logic [2:0] f3, logic b30, logic z,
                       int fw, int mw);
    logic [3:0] alu;
    cur_name = name;
    bus.i_op = op;
    bus.i_funct3 = f3;
    bus.i_funct7b5 = b30;
    cur_imm = imm_of(op);
    alu = exp_alu(op, f3, b30);
    for (int k = 0; k < fw; k++) push("FETCHW", 1'b0, rnd(), e_fetch(1'b0));
    push("FETCH", 1'b1, rnd(), e_fetch(1'b1));
    push("DECODE", rnd(), rnd(), mk(0, 0, 0, 0, 2'b00, 2'b01, 2'b01, 0, 4'b0000));
    case (op)
      OP_LW: begin
        push("MEMADR", rnd(), rnd(), mk(0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 0, 4'b0000));
        for (int k = 0; k < mw; k++)
          push("MEMREADW", 1'b0, rnd(), mk(0, 1, 0, 0, 2'b00, 2'b00, 2'b00, 0, 4'b0000));
        push("MEMREAD", 1'b1, rnd(), mk(0, 1, 0, 0, 2'b00, 2'b00, 2'b00, 0, 4'b0000));
        push("MEMWB", rnd(), rnd(), mk(0, 0, 0, 0, 2'b01, 2'b00, 2'b00, 1, 4'b0000));
      end
      OP_SW: begin
        push("MEMADR", rnd(), rnd(), mk(0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 0, 4'b0000));
        for (int k = 0; k < mw; k++)
          push("MEMWRITEW", 1'b0, rnd(), mk(0, 1, 1, 0, 2'b00, 2'b00, 2'b00, 0, 4'b0000));
        push("MEMWRITE", 1'b1, rnd(), mk(0, 1, 1, 0, 2'b00, 2'b00, 2'b00, 0, 4'b0000));
      end
      OP_R: begin
        push("EXECR", rnd(), rnd(), mk(0, 0, 0, 0, 2'b00, 2'b10, 2'b00, 0, alu));
        push("ALUWB", rnd(), rnd(), mk(0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 1, 4'b0000));
      end
      OP_I: begin
        push("EXECI", rnd(), rnd(), mk(0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 0, alu));
        push("ALUWB", rnd(), rnd(), mk(0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 1, 4'b0000));
      end
      OP_B:
        push("BEQ", rnd(), z, mk(z, 0, 0, 0, 2'b00, 2'b10, 2'b00, 0, 4'b1000));
      OP_JAL: begin
        push("JAL", rnd(), rnd(), mk(1, 0, 0, 0, 2'b00, 2'b01, 2'b10, 0, 4'b0000));
        push("ALUWB", rnd(), rnd(), mk(0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 1, 4'b0000));
      end
      default: begin
`ifdef MULTICYCLE_CTRL_ILLEGAL_TRAP_EN
        for (int k = 0; k < 4; k++)
          push("TRAP", 1'b1, 1'b1, {1'b1, cur_imm, 15'd0});
`endif
      end
    endcase
  endtask

  // Entered at posedge+1; drives the cycle's inputs, compares at the falling edge.
  task automatic drain(int n);
    cyc_t c;
    for (int k = 0; k < n && sb.size() > 0; k++) begin
      c = sb.pop_front();
      bus.i_memReady = c.rdy;
      bus.i_zero = c.z;
      @(negedge i_clk);
      chk(c.tag, 32'(obs()), 32'(c.exp));
      @(posedge i_clk);
      #1;
    end
  endtask

  task automatic run(string name, logic [6:0] op, logic [2:0] f3, logic b30, logic z,
                     int fw, int mw);
    issue(name, op, f3, b30, z, fw, mw);
    drain(sb.size());
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    bus.i_op = 7'd0;
    bus.i_funct3 = 3'd0;
    bus.i_funct7b5 = 1'b0;
    bus.i_zero = 1'b0;
    bus.i_memReady = 1'b1;
    cur_imm = 2'b00;
    @(negedge i_clk);
    chk("reset_vals", 32'(obs()), 32'(e_fetch(1'b0)));
    @(posedge i_clk);
    #1 i_rst_n = 1'b1;

    // Reset in the middle of a stalled store
    issue("sw_rst", OP_SW, 3'b010, 1'b0, 1'b0, 0, 5);
    drain(5);
    i_rst_n = 1'b0;
    bus.i_memReady = 1'b1;
    #2 chk("rst_mid_write", 32'(obs()), 32'(e_fetch(1'b0)));
    sb.delete();
    @(negedge i_clk);
    i_rst_n = 1'b1;
    bus.i_memReady = 1'b0;
    #1 chk("post_rst_fetch", 32'(obs()), 32'(e_fetch(1'b0)));
    @(posedge i_clk);
    #1;

    run("add",   OP_R,   3'b000, 1'b0, 1'b0, 1, 0);
    run("sub",   OP_R,   3'b000, 1'b1, 1'b0, 0, 0);
    run("addi",  OP_I,   3'b000, 1'b1, 1'b0, 0, 0);
    run("lw_w2", OP_LW,  3'b010, 1'b0, 1'b0, 0, 2);
    run("lw_f1", OP_LW,  3'b010, 1'b0, 1'b0, 1, 0);
    run("sw",    OP_SW,  3'b010, 1'b0, 1'b0, 0, 0);
    run("sw_w2", OP_SW,  3'b010, 1'b0, 1'b0, 0, 2);
    run("beq_t", OP_B,   3'b000, 1'b0, 1'b1, 0, 0);
    run("beq_n", OP_B,   3'b001, 1'b1, 1'b0, 0, 0);
    run("jal",   OP_JAL, 3'b000, 1'b0, 1'b0, 0, 0);
    run("slt",   OP_R,   3'b010, 1'b0, 1'b0, 0, 0);
    run("or",    OP_R,   3'b110, 1'b0, 1'b0, 0, 0);
    run("andi",  OP_I,   3'b111, 1'b0, 1'b0, 0, 0);
    run("xor",   OP_R,   3'b100, 1'b1, 1'b0, 0, 0);
    run("slli",  OP_I,   3'b001, 1'b0, 1'b0, 0, 0);
    run("sys",   OP_SYS, 3'b000, 1'b0, 1'b0, 0, 0);
    run("add2",  OP_R,   3'b111, 1'b0, 1'b0, 0, 0);

    // A final reset must clear every enable (and the trap flag when present)
    i_rst_n = 1'b0;
    bus.i_memReady = 1'b1;
    bus.i_op = OP_R;
    cur_imm = imm_of(OP_R);
    #2 chk("final_reset", 32'(obs()), 32'(e_fetch(1'b0)));
    @(negedge i_clk);
    i_rst_n = 1'b1;

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
endmodule
